// File: rtl/popcnt_pkg.sv
// Shared types and elaboration-time helpers for the streaming population counter.
package popcnt_pkg;

  typedef enum logic [1:0] {
    MODE_THRESH = 2'd0,
    MODE_ALL    = 2'd1,
    MODE_ANY    = 2'd2,
    MODE_MAJ    = 2'd3
  } mode_e;

  function automatic int clog2(input int v);
    int r;
    longint x;
    r = 0;
    x = 1;
    while (x < longint'(v)) begin
      x = x * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Number of partial sums entering tree level l when starting from n bits.
  function automatic int level_count(input int n, input int l);
    int c;
    c = n;
    for (int i = 0; i < l; i++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/popcnt_add_level.sv
// One registered adder-tree level: pairwise sums of adjacent partial sums,
// odd leftover passed through, side-band (valid/mode/threshold) carried alongside.
module popcnt_add_level
  import popcnt_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int IN_W  = 1,
  parameter int OUT_W = 2,
  parameter int SB_W  = 1,
  localparam int N_OUT = (N_IN + 1) / 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [N_IN*IN_W-1:0]   sum_i,
  input  logic [SB_W-1:0]        sb_i,
  output logic [N_OUT*OUT_W-1:0] sum_o,
  output logic [SB_W-1:0]        sb_o
);

  logic [N_OUT*OUT_W-1:0] sum_d;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_IN / 2; i++) begin
      sum_d[i*OUT_W +: OUT_W] = OUT_W'(sum_i[(2*i)*IN_W +: IN_W])
                              + OUT_W'(sum_i[(2*i+1)*IN_W +: IN_W]);
    end
    if (N_IN % 2 == 1) begin
      sum_d[(N_OUT-1)*OUT_W +: OUT_W] = OUT_W'(sum_i[(N_IN-1)*IN_W +: IN_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_o <= '0;
      sb_o  <= '0;
    end else if (en) begin
      sum_o <= sum_d;
      sb_o  <= sb_i;
    end
  end

endmodule

// File: rtl/popcnt_stream.sv
// Streaming population counter: pipelined adder tree, per-beat hit decision,
// global-stall valid/ready handshake and a saturating hit accumulator.
module popcnt_stream
  import popcnt_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int ACC_W = 16,
  localparam int CNT_W = clog2(WIDTH + 1),
  localparam int LAT   = clog2(WIDTH) + 1,
  localparam int LVL   = LAT - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [CNT_W-1:0] in_thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_hit,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] acc_hits
);

  // Side-band layout: {valid, mode[1:0], thresh[CNT_W-1:0]}
  localparam int SB_W = 3 + CNT_W;

  logic            en;
  logic [SB_W-1:0] sb_in;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign sb_in    = {in_valid & en, in_mode, in_thresh};

  genvar l;
  for (l = 0; l < LVL; l++) begin : g_lvl
    localparam int NI = level_count(WIDTH, l);
    localparam int NO = (NI + 1) / 2;
    localparam int IW = min_int(l + 1, CNT_W);
    localparam int OW = min_int(l + 2, CNT_W);

    logic [NI*IW-1:0] sum_i;
    logic [SB_W-1:0]  sb_i;
    logic [NO*OW-1:0] sum_o;
    logic [SB_W-1:0]  sb_o;

    if (l == 0) begin : g_head
      assign sum_i = in_data;
      assign sb_i  = sb_in;
    end else begin : g_tail
      assign sum_i = g_lvl[l-1].sum_o;
      assign sb_i  = g_lvl[l-1].sb_o;
    end

    popcnt_add_level #(
      .N_IN  (NI),
      .IN_W  (IW),
      .OUT_W (OW),
      .SB_W  (SB_W)
    ) u_add (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .sum_i (sum_i),
      .sb_i  (sb_i),
      .sum_o (sum_o),
      .sb_o  (sb_o)
    );
  end

  logic [CNT_W-1:0] tree_cnt;
  logic [SB_W-1:0]  tree_sb;
  logic             tree_vld;
  mode_e            tree_mode;
  logic [CNT_W-1:0] tree_thresh;
  logic             hit_d;

  assign tree_cnt    = g_lvl[LVL-1].sum_o;
  assign tree_sb     = g_lvl[LVL-1].sb_o;
  assign tree_vld    = tree_sb[SB_W-1];
  assign tree_mode   = mode_e'(tree_sb[SB_W-2 -: 2]);
  assign tree_thresh = tree_sb[CNT_W-1:0];

  // Threshold above WIDTH can never be reached, so it never hits.
  always_comb begin
    hit_d = 1'b0;
    case (tree_mode)
      MODE_THRESH: hit_d = (tree_cnt >= tree_thresh);
      MODE_ALL:    hit_d = (tree_cnt == CNT_W'(WIDTH));
      MODE_ANY:    hit_d = (tree_cnt != '0);
      MODE_MAJ:    hit_d = (tree_cnt > CNT_W'(WIDTH / 2));
      default:     hit_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_cnt   <= '0;
      out_hit   <= 1'b0;
    end else if (en) begin
      out_valid <= tree_vld;
      out_cnt   <= tree_cnt;
      out_hit   <= hit_d;
    end
  end

  // Clear takes priority over a hit delivered in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hits <= '0;
    end else if (acc_clr) begin
      acc_hits <= '0;
    end else if (out_valid && out_ready && out_hit && (acc_hits != '1)) begin
      acc_hits <= acc_hits + 1'b1;
    end
  end

endmodule
